als_avg_filter: RTL

- Moving-average smoother between the ambient-light SPI reader and the PWM generator in the light-measurer datapath.
- Consumes the reader's valid/value strobe pair and emits a smoothed sample with the same strobe semantics, so it drops in directly ahead of the PWM set/value inputs.
- Removes flicker on the LED brightness that comes from sample-to-sample ALS noise.

---
 rtl/als_avg_filter.sv | 137 +++++++++++++
 1 files changed

// File: rtl/als_avg_filter.sv
// Moving-average smoother for ALS samples: an N-entry ring buffer plus a running sum.
// Define ALS_FILT_DEADBAND_EN to suppress output strobes for changes of DEADBAND or less.
module als_avg_filter #(
  parameter int WIDTH      = 8,
  parameter int DEPTH_LOG2 = 2,
  parameter int DEADBAND   = 2
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             flush_i,
  input  logic             valid_i,
  input  logic [WIDTH-1:0] value_i,
  output logic             valid_o,
  output logic [WIDTH-1:0] value_o,
  output logic             seeded_o
);

  localparam int N    = 1 << DEPTH_LOG2;
  localparam int ACCW = WIDTH + DEPTH_LOG2;

  if (DEPTH_LOG2 < 1 || DEPTH_LOG2 > 4 || DEADBAND < 0) begin : g_param_check
    $error("als_avg_filter: DEPTH_LOG2 must be 1..4 and DEADBAND non-negative");
  end

  // Strobe semantics: valid_i marks value_i for exactly one cycle and there is no
  // back-pressure. valid_o pulses for one cycle one clock later, and value_o holds
  // its value until the next pulse.

  typedef enum logic {EMPTY = 1'b0, RUN = 1'b1} state_t;

  // Reset asserts at once but releases only on the second clk_i edge.
  logic [1:0] rst_sync_q;
  logic       rst_n;

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) rst_sync_q <= 2'b00;
    else        rst_sync_q <= {rst_sync_q[0], 1'b1};
  end

  assign rst_n = rst_sync_q[1];

  state_t                state_q, state_d;
  logic [WIDTH-1:0]      ring_q [N];
  logic [WIDTH-1:0]      ring_d [N];
  logic [ACCW-1:0]       acc_q, acc_d;
  logic [DEPTH_LOG2-1:0] ptr_q, ptr_d;
  logic [WIDTH-1:0]      value_q, value_d;
  logic                  valid_q, valid_d;

  logic [ACCW-1:0]       acc_sum;
  logic [WIDTH-1:0]      avg_next;
  logic                  seed;
  logic                  strobe_run;

  // The oldest entry is always part of acc_q, so this cannot underflow.
  assign acc_sum  = acc_q + ACCW'(value_i) - ACCW'(ring_q[ptr_q]);
  assign avg_next = acc_sum[ACCW-1:DEPTH_LOG2];
  assign seed     = valid_i && (flush_i || (state_q == EMPTY));

`ifdef ALS_FILT_DEADBAND_EN
  logic [WIDTH-1:0]        last_q, last_d;
  logic signed [WIDTH:0]   diff;
  logic signed [WIDTH:0]   mag;

  assign diff       = $signed({1'b0, avg_next}) - $signed({1'b0, last_q});
  assign mag        = diff[WIDTH] ? -diff : diff;
  assign strobe_run = mag > $signed((WIDTH+1)'(DEADBAND));
`else
  assign strobe_run = 1'b1;
`endif

  always_comb begin
    state_d = state_q;
    ring_d  = ring_q;
    acc_d   = acc_q;
    ptr_d   = ptr_q;
    value_d = value_q;
    valid_d = 1'b0;
`ifdef ALS_FILT_DEADBAND_EN
    last_d  = last_q;
`endif
    if (seed) begin
      // A seed fills the whole window so the first average equals the sample.
      for (int i = 0; i < N; i++) ring_d[i] = value_i;
      acc_d   = ACCW'(value_i) << DEPTH_LOG2;
      ptr_d   = '0;
      value_d = value_i;
      valid_d = 1'b1;
      state_d = RUN;
`ifdef ALS_FILT_DEADBAND_EN
      last_d  = value_i;
`endif
    end else if (flush_i) begin
      state_d = EMPTY;
    end else if (valid_i) begin
      ring_d[ptr_q] = value_i;
      acc_d         = acc_sum;
      ptr_d         = ptr_q + DEPTH_LOG2'(1);
      if (strobe_run) begin
        value_d = avg_next;
        valid_d = 1'b1;
`ifdef ALS_FILT_DEADBAND_EN
        last_d  = avg_next;
`endif
      end
    end
  end

  always_ff @(posedge clk_i or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= EMPTY;
      for (int i = 0; i < N; i++) ring_q[i] <= '0;
      acc_q   <= '0;
      ptr_q   <= '0;
      value_q <= '0;
      valid_q <= 1'b0;
`ifdef ALS_FILT_DEADBAND_EN
      last_q  <= '0;
`endif
    end else begin
      state_q <= state_d;
      ring_q  <= ring_d;
      acc_q   <= acc_d;
      ptr_q   <= ptr_d;
      value_q <= value_d;
      valid_q <= valid_d;
`ifdef ALS_FILT_DEADBAND_EN
      last_q  <= last_d;
`endif
    end
  end

  assign valid_o  = valid_q;
  assign value_o  = value_q;
  assign seeded_o = (state_q == RUN);

endmodule
